// File: rtl/dataflow_pkg.sv
// Shared pipeline types: stage order, fetch/data FSM encodings, register index width.
// Stage-valid bit positions are derived from stages_t so the two can never drift apart.
package dataflow_pkg;

  localparam int RegIdxW = 5;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback
  } stages_t;

  typedef enum logic [1:0] {
    IfIdle,
    IfWait,
    IfKill
  } fetch_state_t;

  typedef enum logic {
    DmIdle,
    DmWait
  } dmem_state_t;

  // Fetch has no valid bit, so every later stage shifts down by one position.
  function automatic int valid_bit(stages_t s);
    return int'(s) - 1;
  endfunction

  localparam int VId  = valid_bit(StDecode);
  localparam int VEx  = valid_bit(StExecute);
  localparam int VMem = valid_bit(StMemory);
  localparam int VWb  = valid_bit(StWriteback);

endpackage

// File: rtl/pipeline_controller_if.sv
// Instruction- and data-memory request/acknowledge pair; ack is held high until req drops.
// The controller is the master, the memory side is the slave.
interface pipeline_controller_if;
  logic inst_req;
  logic inst_ack;
  logic data_req;
  logic data_ack;

  modport master (output inst_req, output data_req, input inst_ack, input data_ack);
  modport slave  (input inst_req, input data_req, output inst_ack, output data_ack);
endinterface

// File: rtl/pipeline_controller_load_use_detector.sv
// Combinational load-use hazard: a load in EX whose rd feeds a source of the instruction in ID.
// Zero latency; writes to x0 never create a hazard.
module load_use_detector
  import dataflow_pkg::*;
(
  input  logic               ex_vld,
  input  logic               ex_mem_read_enable,
  input  logic [RegIdxW-1:0] ex_rd,
  input  logic               id_vld,
  input  logic [RegIdxW-1:0] id_rs1,
  input  logic [RegIdxW-1:0] id_rs2,
  output logic               load_use
);

  assign load_use = ex_vld && ex_mem_read_enable && (ex_rd != '0) && id_vld &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_controller.sv
// Stage-valid bookkeeping, register enables and memory handshakes for the 5-stage core.
// Enables are combinational; the pipeline steps on fetch accept, load-use bubble or redirect; mem wait freezes all but MEM/WB.
module pipeline_controller
  import dataflow_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [RegIdxW-1:0]    id_rs1,
  input  logic [RegIdxW-1:0]    id_rs2,
  input  logic [RegIdxW-1:0]    ex_rd,
  input  logic                  ex_mem_read_enable,
  input  logic                  ex_redirect,
  input  logic                  mem_access,
  pipeline_controller_if.master mem_if,
  output logic                  fetch_start,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic [3:0]            stage_valid,
  output logic                  load_use_stall
);

  fetch_state_t fs_q, fs_d;
  dmem_state_t  dm_q, dm_d;
  logic [3:0]   valid_q, valid_d;
  logic         fetch_start_q, inst_req_q, data_req_q;

  logic load_use, mem_done, mem_stall, redirect, front_stall, accept, step;

  load_use_detector u_load_use (
    .ex_vld             (valid_q[VEx]),
    .ex_mem_read_enable (ex_mem_read_enable),
    .ex_rd              (ex_rd),
    .id_vld             (valid_q[VId]),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .load_use           (load_use)
  );

  assign mem_done       = (dm_q == DmWait) && mem_if.data_ack;
  assign mem_stall      = valid_q[VMem] && mem_access && !mem_done;
  assign load_use_stall = load_use && !mem_stall;
  assign redirect       = valid_q[VEx] && ex_redirect && !mem_stall;
  assign front_stall    = mem_stall || load_use;
  assign accept         = (fs_q == IfWait) && mem_if.inst_ack && !front_stall && !redirect;
  assign step           = accept || load_use_stall || redirect;

  assign pc_en       = accept || redirect;
  assign if_id_en    = accept;
  assign id_ex_en    = accept || load_use_stall;
  assign ex_mem_en   = step;
  assign mem_wb_en   = step || mem_stall || mem_done;
  assign stage_valid = valid_q;
  assign fetch_start = fetch_start_q;

  assign mem_if.inst_req = inst_req_q;
  assign mem_if.data_req = data_req_q;

  always_comb begin
    fs_d = fs_q;
    unique case (fs_q)
      // A redirect in IfIdle latches the stale PC, so that fetch must be drained too.
      IfIdle:  fs_d = redirect ? IfKill : IfWait;
      IfWait: begin
        if (redirect)    fs_d = mem_if.inst_ack ? IfIdle : IfKill;
        else if (accept) fs_d = IfIdle;
      end
      IfKill:  if (mem_if.inst_ack) fs_d = IfIdle;
      default: fs_d = IfIdle;
    endcase

    dm_d = dm_q;
    unique case (dm_q)
      DmIdle:  if (valid_q[VMem] && mem_access) dm_d = DmWait;
      DmWait:  if (mem_if.data_ack) dm_d = DmIdle;
      default: dm_d = DmIdle;
    endcase

    valid_d       = valid_q;
    valid_d[VId]  = accept ? 1'b1 : (redirect ? 1'b0 : valid_q[VId]);
    valid_d[VEx]  = accept ? valid_q[VId] : ((load_use_stall || redirect) ? 1'b0 : valid_q[VEx]);
    // A finished access retires to WB even when the rest of the pipe is waiting on fetch.
    valid_d[VMem] = step ? valid_q[VEx] : (mem_done ? 1'b0 : valid_q[VMem]);
    valid_d[VWb]  = (step || mem_done) && valid_q[VMem];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fs_q          <= IfIdle;
      dm_q          <= DmIdle;
      valid_q       <= '0;
      fetch_start_q <= 1'b1;
      inst_req_q    <= 1'b0;
      data_req_q    <= 1'b0;
    end else begin
      fs_q          <= fs_d;
      dm_q          <= dm_d;
      valid_q       <= valid_d;
      fetch_start_q <= (fs_d == IfIdle);
      inst_req_q    <= (fs_d != IfIdle);
      data_req_q    <= (dm_d == DmWait);
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed scenarios for pipeline_controller with hand-derived per-cycle expectations.
module tb_pipeline_controller;
  import dataflow_pkg::*;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic [RegIdxW-1:0] id_rs1, id_rs2, ex_rd;
  logic               ex_mem_read_enable, ex_redirect, mem_access;
  logic               fetch_start, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic [3:0]         stage_valid;
  logic               load_use_stall;
  int                 errors = 0;
  int                 checks = 0;

  pipeline_controller_if mem_if ();

  pipeline_controller dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .ex_rd              (ex_rd),
    .ex_mem_read_enable (ex_mem_read_enable),
    .ex_redirect        (ex_redirect),
    .mem_access         (mem_access),
    .mem_if             (mem_if.master),
    .fetch_start        (fetch_start),
    .pc_en              (pc_en),
    .if_id_en           (if_id_en),
    .id_ex_en           (id_ex_en),
    .ex_mem_en          (ex_mem_en),
    .mem_wb_en          (mem_wb_en),
    .stage_valid        (stage_valid),
    .load_use_stall     (load_use_stall)
  );

  always #5 clock = ~clock;

  // {fetch_start, inst_req, pc_en, stage_valid} for cycles 1..11 after reset with ack held.
  logic [6:0] fill_tab [11] = '{
    7'b100_0000, 7'b011_0000, 7'b100_0001, 7'b011_0001, 7'b100_0011, 7'b011_0011,
    7'b100_0111, 7'b011_0111, 7'b100_1111, 7'b011_0111, 7'b100_1111
  };

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read_enable = 1'b0; ex_redirect = 1'b0; mem_access = 1'b0;
    mem_if.inst_ack = 1'b0; mem_if.data_ack = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    #2 reset_n = 1'b0;
    ex_redirect = 1'b1; mem_access = 1'b1; ex_mem_read_enable = 1'b1;
    ex_rd = 5'd3; id_rs1 = 5'd3; id_rs2 = 5'd0;
    mem_if.inst_ack = 1'b1; mem_if.data_ack = 1'b1;
    @(posedge clock);
    #3;
    got = {mem_if.inst_req, mem_if.data_req, fetch_start, pc_en, if_id_en, id_ex_en,
           ex_mem_en, mem_wb_en, load_use_stall, stage_valid};
    checks++;
    if (got !== 13'b0010000000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", got, 13'b0010000000000);
    end
  endtask

  task automatic test_fill();
    logic [6:0] got;
    reset_dut();
    mem_if.inst_ack = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #3;
      got = {fetch_start, mem_if.inst_req, pc_en, stage_valid};
      checks++;
      if (got !== fill_tab[i]) begin
        errors++;
        $display("FAIL fill_cycle%0d: got %b want %b", i + 1, got, fill_tab[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    logic [5:0] got;
    reset_dut();
    mem_if.inst_ack = 1'b1;
    repeat (4) next_cycle();
    ex_mem_read_enable = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #3;
    got = {1'b0, load_use_stall, pc_en, if_id_en, id_ex_en, ex_mem_en};
    checks++;
    if (got !== 6'b010011) begin
      errors++;
      $display("FAIL lu_stall: got %b want %b", got, 6'b010011);
    end
    next_cycle();
    ex_mem_read_enable = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    #3;
    got = {load_use_stall, pc_en, stage_valid};
    checks++;
    if (got !== 6'b01_0101) begin
      errors++;
      $display("FAIL lu_bubble: got %b want %b", got, 6'b01_0101);
    end
    next_cycle();
    ex_mem_read_enable = 1'b1;
    #3;
    got = {stage_valid, load_use_stall, id_ex_en};
    checks++;
    if (got !== 6'b1011_00) begin
      errors++;
      $display("FAIL lu_x0_ignored: got %b want %b", got, 6'b1011_00);
    end
    next_cycle();
    ex_rd = 5'd7; id_rs1 = 5'd7;
    #3;
    got = {3'b000, load_use_stall, pc_en, if_id_en};
    checks++;
    if (got !== 6'b000100) begin
      errors++;
      $display("FAIL lu_rs1_hold: got %b want %b", got, 6'b000100);
    end
    next_cycle();
    ex_mem_read_enable = 1'b0; ex_rd = '0; id_rs1 = '0;
    #3;
    got = {1'b0, stage_valid, pc_en};
    checks++;
    if (got !== 6'b0_0101_1) begin
      errors++;
      $display("FAIL lu_resume: got %b want %b", got, 6'b0_0101_1);
    end
  endtask

  task automatic test_mem_stall();
    logic [9:0] got;
    reset_dut();
    mem_if.inst_ack = 1'b1;
    repeat (6) next_cycle();
    mem_access = 1'b1;
    #3;
    got = {mem_if.data_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, stage_valid};
    checks++;
    if (got !== 10'b000001_0111) begin
      errors++;
      $display("FAIL ms_idle_stall: got %b want %b", got, 10'b000001_0111);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #3;
      got = {mem_if.data_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, stage_valid};
      checks++;
      if (got !== 10'b100001_0111) begin
        errors++;
        $display("FAIL ms_wait%0d: got %b want %b", i, got, 10'b100001_0111);
      end
    end
    next_cycle();
    mem_if.data_ack = 1'b1;
    #3;
    got = {4'b0000, mem_if.data_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    checks++;
    if (got !== 10'b0000_111111) begin
      errors++;
      $display("FAIL ms_ack: got %b want %b", got, 10'b0000_111111);
    end
    next_cycle();
    mem_if.data_ack = 1'b0; mem_access = 1'b0;
    #3;
    got = {5'b00000, mem_if.data_req, stage_valid};
    checks++;
    if (got !== 10'b00000_0_1111) begin
      errors++;
      $display("FAIL ms_release: got %b want %b", got, 10'b00000_0_1111);
    end
  endtask

  task automatic test_redirect_kill();
    logic [5:0] got;
    reset_dut();
    mem_if.inst_ack = 1'b1;
    repeat (5) next_cycle();
    mem_if.inst_ack = 1'b0; ex_redirect = 1'b1;
    #3;
    got = {2'b00, pc_en, if_id_en, ex_mem_en, mem_if.inst_req};
    checks++;
    if (got !== 6'b00_1011) begin
      errors++;
      $display("FAIL rk_redirect: got %b want %b", got, 6'b00_1011);
    end
    next_cycle();
    ex_redirect = 1'b0;
    #3;
    got = {mem_if.inst_req, fetch_start, stage_valid};
    checks++;
    if (got !== 6'b10_0100) begin
      errors++;
      $display("FAIL rk_kill: got %b want %b", got, 6'b10_0100);
    end
    next_cycle();
    mem_if.inst_ack = 1'b1;
    #3;
    got = {3'b000, pc_en, if_id_en, mem_if.inst_req};
    checks++;
    if (got !== 6'b000_001) begin
      errors++;
      $display("FAIL rk_discard: got %b want %b", got, 6'b000_001);
    end
    next_cycle();
    mem_if.inst_ack = 1'b0;
    #3;
    got = {fetch_start, mem_if.inst_req, stage_valid};
    checks++;
    if (got !== 6'b10_0100) begin
      errors++;
      $display("FAIL rk_refetch: got %b want %b", got, 6'b10_0100);
    end
  endtask

  task automatic test_redirect_ack();
    logic [5:0] got;
    reset_dut();
    mem_if.inst_ack = 1'b1;
    repeat (5) next_cycle();
    ex_redirect = 1'b1;
    #3;
    got = {4'b0000, pc_en, if_id_en};
    checks++;
    if (got !== 6'b0000_10) begin
      errors++;
      $display("FAIL ra_same_cycle: got %b want %b", got, 6'b0000_10);
    end
    next_cycle();
    ex_redirect = 1'b0;
    #3;
    got = {fetch_start, mem_if.inst_req, stage_valid};
    checks++;
    if (got !== 6'b10_0100) begin
      errors++;
      $display("FAIL ra_idle: got %b want %b", got, 6'b10_0100);
    end
    repeat (2) next_cycle();
    #3;
    got = {2'b00, stage_valid};
    checks++;
    if (got !== 6'b00_1001) begin
      errors++;
      $display("FAIL ra_resume: got %b want %b", got, 6'b00_1001);
    end
  endtask

  task automatic test_redirect_mem();
    logic [5:0] got;
    reset_dut();
    mem_if.inst_ack = 1'b1;
    repeat (6) next_cycle();
    mem_access = 1'b1; ex_redirect = 1'b1;
    #3;
    got = {4'b0000, pc_en, ex_mem_en};
    checks++;
    if (got !== 6'b000000) begin
      errors++;
      $display("FAIL rm_idle_defer: got %b want %b", got, 6'b000000);
    end
    next_cycle();
    #3;
    got = {4'b0000, pc_en, mem_if.data_req};
    checks++;
    if (got !== 6'b0000_01) begin
      errors++;
      $display("FAIL rm_wait_defer: got %b want %b", got, 6'b0000_01);
    end
    next_cycle();
    mem_if.data_ack = 1'b1;
    #3;
    got = {2'b00, pc_en, if_id_en, ex_mem_en, mem_wb_en};
    checks++;
    if (got !== 6'b00_1011) begin
      errors++;
      $display("FAIL rm_fire: got %b want %b", got, 6'b00_1011);
    end
    next_cycle();
    mem_if.data_ack = 1'b0; mem_access = 1'b0; ex_redirect = 1'b0;
    #3;
    got = {stage_valid, fetch_start, mem_if.data_req};
    checks++;
    if (got !== 6'b1100_1_0) begin
      errors++;
      $display("FAIL rm_after: got %b want %b", got, 6'b1100_1_0);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got;
    reset_dut();
    next_cycle();
    #3;
    checks++;
    if (mem_if.inst_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req_before: got %b want %b", mem_if.inst_req, 1'b1);
    end
    #1 reset_n = 1'b0;
    #1;
    got = {mem_if.inst_req, fetch_start, pc_en};
    checks++;
    if (got !== 3'b010) begin
      errors++;
      $display("FAIL rst_mid_drop: got %b want %b", got, 3'b010);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_load_use();
    test_mem_stall();
    test_redirect_kill();
    test_redirect_ack();
    test_redirect_mem();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Sequencing controller for the 5-stage pipelined RV core: owns the per-stage valid bits and generates the enable and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Runs the instruction-fetch and data-memory request handshakes. Resolves load-use stalls, memory-wait freezes and EX-stage redirects. Sits beside the dataflow, which keeps all data fields and only honours these enables.

## Interface
- No parameters (register index width 5 is fixed).
- clock  in  1  core clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- ex_rd  in  5  destination of the instruction in EX
- ex_mem_read_enable  in  1  EX instruction is a load
- ex_redirect  in  1  EX instruction is a taken branch or jump (target computed by the dataflow)
- mem_access  in  1  MEM instruction reads or writes memory
- inst_ack, data_ack  in  1 each  memory acknowledges; held high with data until the request drops
- inst_req, data_req  out  1 each  memory requests
- fetch_start  out  1  latch PC into the fetch-address register
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
- stage_valid  out  4  valid bits of ID, EX, MEM, WB, in that order from bit 0
- load_use_stall  out  1  debug/perf strobe

## Operation
- Fetch FSM, states IfIdle, IfWait, IfKill:
  - IfIdle: fetch_start=1, then go to IfWait.
  - IfWait: inst_req=1.
    - On inst_ack && no front stall: if_id_en=1, pc_en=1 (PC+4), ID valid next=1, go to IfIdle.
    - On inst_ack with a front stall: stay in IfWait (ack is held).
  - IfKill: inst_req=1. On inst_ack, discard the data and go to IfIdle.
- Data FSM, states DmIdle, DmWait:
  - DmIdle: MEM valid && mem_access goes to DmWait.
  - DmWait: data_req=1. On data_ack, go to DmIdle.
  - data_req is therefore low for at least one cycle between accesses.
- mem_stall = MEM valid && mem_access && !(DmWait && data_ack).
  - pc, IF/ID, ID/EX and EX/MEM are frozen.
  - mem_wb_en=1 and WB valid next=0 (bubble).
  - Any redirect is deferred while mem_stall is high.
- load_use = EX valid && ex_mem_read_enable && ex_rd≠0 && ID valid && (ex_rd==id_rs1 || ex_rd==id_rs2).
  - pc and IF/ID are held.
  - id_ex_en=1 with EX valid next=0.
  - EX/MEM and MEM/WB advance.
- redirect = EX valid && ex_redirect && !mem_stall.
  - pc_en=1 (dataflow selects the target).
  - ID and EX valid next=0.
  - IfWait without inst_ack goes to IfKill.
  - IfWait with inst_ack the same cycle: the instruction is discarded and the FSM goes to IfIdle.
- Front stall = mem_stall || load_use. Redirect has priority over fetch accept.
- Valid bits otherwise shift with their enables; WB valid clears the cycle after writeback.

## Timing
- Reset, asynchronous: all valid bits 0, IfIdle, DmIdle.
  - While reset_n is low, every output is 0 except fetch_start.
  - fetch_start=1 in the first cycle after release.
- Enables and strobes are combinational from state and inputs. Requests are functions of FSM state only.
- Minimum fetch is 2 cycles per instruction (IfIdle, then IfWait with immediate ack).
- Minimum MEM residency for an access is 2 cycles.
- load_use inserts exactly one bubble.
- Redirect penalty is 2 squashed slots plus any IfKill drain.
- load_use and redirect are mutually exclusive (a load cannot redirect). mem_stall overrides both.
- Reset mid-handshake: requests drop immediately. Memory must tolerate an abandoned request.

## Structure
- fetch_state_t {IfIdle, IfWait, IfKill} and dmem_state_t {DmIdle, DmWait} go in dataflow_pkg, beside stages_t.
- stage_valid indexing follows stages_t order minus Fetch.
- One combinational sub-module, load_use_detector, produces load_use.
- The FSMs and valid bits stay in pipeline_controller.

## Test plan
- Reset release, inst_ack held high, no hazards:
  - fetch_start in cycle 1 and inst_req in cycle 2.
  - stage_valid reaches 4'b1111 after 8 cycles with no bubbles between instructions.
- EX load with ex_rd=5 and ID id_rs2=5:
  - load_use_stall for one cycle; pc_en=0, if_id_en=0.
  - EX valid drops for one cycle, then resumes.
- MEM store, data_ack after 3 cycles in DmWait:
  - data_req high for 3 cycles, pc and IF/ID/ID/EX/EX/MEM frozen for 3 cycles.
  - One WB bubble per stall cycle; data_req low the cycle after ack.
- ex_redirect while IfWait with no ack:
  - pc_en=1, ID and EX valid cleared, FSM goes to IfKill.
  - Ack 2 cycles later is discarded, then fetch_start.
- ex_redirect and inst_ack in the same cycle: the fetched instruction never sets ID valid, and the FSM goes to IfIdle.
- ex_redirect during mem_stall: pc_en stays 0 until data_ack, and the redirect fires in that cycle.
